// File: rtl/regbus_pkg.sv
// Shared constants, types and the operand-select helper for the register-bank bus controller.
package regbus_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    // x0 reads as zero; a same-cycle write-back wins over the value the bank presents.
    function automatic word_t pick_operand(
        input reg_addr_t src,
        input logic      wr_en,
        input reg_addr_t wr_addr,
        input word_t     wr_data,
        input word_t     fallback
    );
        if (src == '0)
            return '0;
        else if (wr_en && (wr_addr == src))
            return wr_data;
        else
            return fallback;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Address-to-one-hot decoder with enable; index 0 never decodes because x0 has no storage.
module onehot_dec #(
    parameter int AW = 5,
    parameter int N  = 32
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  onehot
);

    // NOTE: assign a default before any conditional update so no latch is inferred.
    always_comb begin
        onehot = '0;
        if (en && (addr != '0))
            onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/regbus_ctrl.sv
// Register-bank bus controller: two-handshake operand reads over shared A/B buses,
// combinational write-back strobes, x0 as zero and same-cycle write-back forwarding.
module regbus_ctrl
    import regbus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    output logic [NREGS-1:0] enable_a,
    output logic [NREGS-1:0] enable_b,
    output logic [NREGS-1:0] store,
    output logic [XLEN-1:0]  data_out,
    input  logic [XLEN-1:0]  bus_a,
    input  logic [XLEN-1:0]  bus_b
);

    state_t            state_q, state_d;
    reg_addr_t         rs1_q, rs2_q;
    word_t             rs1_data_q, rs2_data_q;
    logic [NREGS-1:0]  en_a_q, en_b_q;
    logic [NREGS-1:0]  dec_a, dec_b;
    logic              accept;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = DRIVE;
            end
            DRIVE: state_d = HOLD;
            HOLD: begin
                req_ready = rsp_ready;
                if (rsp_ready)
                    state_d = req_valid ? DRIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset)
            req_ready = 1'b0;
    end

    assign accept = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Enables are decoded from the incoming request so they are registered and high only in DRIVE.
    onehot_dec #(.AW(AW), .N(NREGS)) u_dec_a (
        .en     (accept),
        .addr   (rs1),
        .onehot (dec_a)
    );

    onehot_dec #(.AW(AW), .N(NREGS)) u_dec_b (
        .en     (accept),
        .addr   (rs2),
        .onehot (dec_b)
    );

    onehot_dec #(.AW(AW), .N(NREGS)) u_dec_store (
        .en     (wr_en && !reset),
        .addr   (wr_addr),
        .onehot (store)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            en_a_q     <= '0;
            en_b_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            en_a_q <= dec_a;
            en_b_q <= dec_b;
            if (accept) begin
                rs1_q <= rs1;
                rs2_q <= rs2;
            end
            // DRIVE captures from the buses; HOLD keeps the operands coherent with write-back.
            if (state_q == DRIVE) begin
                rs1_data_q <= pick_operand(rs1_q, wr_en, wr_addr, wr_data, bus_a);
                rs2_data_q <= pick_operand(rs2_q, wr_en, wr_addr, wr_data, bus_b);
            end else if (state_q == HOLD) begin
                rs1_data_q <= pick_operand(rs1_q, wr_en, wr_addr, wr_data, rs1_data_q);
                rs2_data_q <= pick_operand(rs2_q, wr_en, wr_addr, wr_data, rs2_data_q);
            end
        end
    end

    assign enable_a  = en_a_q;
    assign enable_b  = en_b_q;
    assign rsp_valid = (state_q == HOLD);
    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign data_out  = wr_data;

endmodule

// File: tb/tb_regbus_ctrl.sv
// Directed bench for regbus_ctrl: a behavioural bank drives the buses, a scoreboard
// queue holds expected operand pairs and a monitor checks each response handshake.
module tb_regbus_ctrl;
    import regbus_pkg::*;

    typedef struct packed {
        word_t d1;
        word_t d2;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [AW-1:0]    rs1, rs2;
    logic             rsp_valid, rsp_ready;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic [NREGS-1:0] enable_a, enable_b, store;
    logic [XLEN-1:0]  data_out;
    logic [XLEN-1:0]  bus_a, bus_b;

    word_t bank [NREGS];
    rsp_t  exp_q [$];
    rsp_t  exp_item;
    int    total = 0;
    int    bad   = 0;
    int    n_rsp = 0;

    always #5 clk = ~clk;

    regbus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .enable_a  (enable_a),
        .enable_b  (enable_b),
        .store     (store),
        .data_out  (data_out),
        .bus_a     (bus_a),
        .bus_b     (bus_b)
    );

    // Bank model: commits on store, drives a bus only when its enable is set, else the bus floats high.
    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++)
            if (store[i]) bank[i] <= data_out;
    end

    always_comb begin
        bus_a = 32'hFFFF_FFFF;
        bus_b = 32'hFFFF_FFFF;
        for (int i = 0; i < NREGS; i++) begin
            if (enable_a[i]) bus_a = bank[i];
            if (enable_b[i]) bus_b = bank[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed response handshake pops and checks one expected pair.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got %h/%h expected no response", rs1_data, rs2_data);
            end else begin
                exp_item = exp_q.pop_front();
                check("rsp_rs1_data", rs1_data, exp_item.d1);
                check("rsp_rs2_data", rs2_data, exp_item.d2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bank_write(input reg_addr_t a, input word_t d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rs1 = '0; rs2 = '0; rsp_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_1111;
        tick();
        tick();
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_enable_a", enable_a, 32'd0);
        check("reset_store", store, 32'd0);
        check("reset_rs1_data", rs1_data, 32'd0);
        wr_en = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Preload the bank through the write path.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        #1;
        check("store_x5", store, 32'h0000_0020);
        check("data_out_x5", data_out, 32'h1234_5678);
        tick();
        wr_en = 1'b0;
        bank_write(5'd6, 32'hDEAD_BEEF);
        bank_write(5'd7, 32'h0000_0001);
        bank_write(5'd9, 32'h0000_0099);

        // Basic read x5/x6.
        rsp_ready = 1'b1;
        req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
        exp_q.push_back('{32'h1234_5678, 32'hDEAD_BEEF});
        tick();
        req_valid = 1'b0;
        check("t1_enable_a", enable_a, 32'h0000_0020);
        check("t1_enable_b", enable_b, 32'h0000_0040);
        check("t1_rsp_valid_drive", {31'd0, rsp_valid}, 32'd0);
        check("t1_req_ready_drive", {31'd0, req_ready}, 32'd0);
        tick();
        check("t1_enable_a_hold", enable_a, 32'd0);
        check("t1_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
        tick();
        check("t1_rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);

        // x0 sources with floating buses, plus a discarded write to x0.
        req_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_0777;
        exp_q.push_back('{32'h0, 32'h0});
        #1;
        check("t2_store_x0", store, 32'd0);
        check("t2_data_out", data_out, 32'h0000_0777);
        tick();
        req_valid = 1'b0;
        check("t2_enable_a", enable_a, 32'd0);
        check("t2_enable_b", enable_b, 32'd0);
        tick();
        wr_en = 1'b0;
        tick();

        // Same-cycle write-back bypass during DRIVE.
        req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd0;
        exp_q.push_back('{32'hA5A5_A5A5, 32'h0});
        tick();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        #1;
        check("t3_enable_a", enable_a, 32'h0000_0080);
        check("t3_bus_a_old", bus_a, 32'h0000_0001);
        check("t3_store_x7", store, 32'h0000_0080);
        tick();
        wr_en = 1'b0;
        tick();

        // Held response with coherence write, then back-to-back request rs1 = rs2 = 9.
        rsp_ready = 1'b0;
        req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
        exp_q.push_back('{32'h0000_0042, 32'hDEAD_BEEF});
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
            check("t4_req_ready_held", {31'd0, req_ready}, 32'd0);
            wr_en = (i == 1);
            wr_addr = 5'd5; wr_data = 32'h0000_0042;
            tick();
        end
        wr_en = 1'b0;
        check("t4_rs1_data_updated", rs1_data, 32'h0000_0042);
        check("t4_rs2_data_kept", rs2_data, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        req_valid = 1'b1; rs1 = 5'd9; rs2 = 5'd9;
        exp_q.push_back('{32'h0000_0099, 32'h0000_0099});
        #1;
        check("t4_req_ready_b2b", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("t6_enable_a", enable_a, 32'h0000_0200);
        check("t6_enable_b", enable_b, 32'h0000_0200);
        check("t6_rsp_valid_drive", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("t6_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
        tick();

        // Reset during DRIVE drops the request.
        req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
        tick();
        req_valid = 1'b0;
        check("t5_enable_a_drive", enable_a, 32'h0000_0020);
        reset = 1'b1;
        tick();
        check("t5_enable_a", enable_a, 32'd0);
        check("t5_enable_b", enable_b, 32'd0);
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_rs1_data", rs1_data, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b0;
        tick();
        check("t5_idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("t5_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        tick();

        check("responses_seen", n_rsp, 5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbus_ctrl.md
Name: regbus_ctrl

Overview:
- Bus-side controller for the register bank; it sits between the decode/execute stage and the 32 tri-state bank registers.
- Read side: takes an operand-read request (rs1, rs2) over a valid/ready handshake and drives one-hot enable_a/enable_b into the bank. It samples the shared A/B buses and returns both operands over a second valid/ready handshake.
- Write side: decodes write-back into one-hot store strobes plus the broadcast data word.
- Handles x0 as constant zero and forwards same-cycle write-back into the read path.

Parameters:
XLEN, 32, data width of buses and registers
NREGS, 32, number of bank registers (index 0 = x0)
AW, 5, register address width, equal to clog2(NREGS)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous reset, active-high
req_valid  in  1  read request valid
req_ready  out  1  controller can accept a request
rs1  in  AW  source register for bus A
rs2  in  AW  source register for bus B
rsp_valid  out  1  rs1_data/rs2_data valid
rsp_ready  in  1  consumer accepts the response
rs1_data  out  XLEN  operand 1
rs2_data  out  XLEN  operand 2
wr_en  in  1  write-back request (always accepted)
wr_addr  in  AW  write-back destination
wr_data  in  XLEN  write-back value
enable_a  out  NREGS  one-hot bus-A drive enables to the bank
enable_b  out  NREGS  one-hot bus-B drive enables to the bank
store  out  NREGS  one-hot store strobes to the bank
data_out  out  XLEN  broadcast write data to the bank
bus_a  in  XLEN  resolved bus A value
bus_b  in  XLEN  resolved bus B value

Behaviour:
- Reset (synchronous, active-high) takes priority over everything, including an in-flight request, which is dropped.
  - While reset is high and on the first cycle after it: state = IDLE, enable_a = enable_b = 0, rsp_valid = 0, rs1_data = rs2_data = 0.
  - req_ready is 0 while reset is high.
  - store is 0 while reset is high, regardless of wr_en.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: req_ready = 1. On req_valid, latch rs1/rs2 and go to DRIVE.
  - DRIVE: enable_a = onehot(rs1_q) and enable_b = onehot(rs2_q), both registered outputs. Bit 0 is never set, so an x0 source leaves the bus undriven. req_ready = 0. At the end of the cycle, capture operands and go to HOLD.
  - HOLD: enables = 0 and rsp_valid = 1. Data is stable until rsp_ready.
    - On rsp_ready alone: go to IDLE.
    - req_ready = rsp_ready in HOLD. If req_valid && rsp_ready, latch the new request and go directly to DRIVE (back-to-back).
- Enables are asserted only in DRIVE; at most one bit of each vector is high.
- Operand capture, per operand:
  - If the source is 0: result is 0, and the bus is ignored.
  - Else if wr_en and wr_addr equals the source in the same cycle: result is wr_data (bypass, because the bank still drives the old value that cycle).
  - Otherwise: result is bus_a (operand 1) or bus_b (operand 2).
- HOLD coherence: if wr_en targets a nonzero latched source while in HOLD, the corresponding held operand updates to wr_data on that edge. rsp_valid stays high. The consumer may observe the change.
- Write path is combinational:
  - store = onehot(wr_addr) when wr_en && wr_addr != 0 && !reset, else 0.
  - data_out = wr_data.
  - The bank commits on the same clk edge. Writes to x0 are discarded.
- Latency: request accepted at edge N; enables high in cycle N+1; rsp_valid high from N+2. Throughput is 1 response per 2 cycles.
- rs1 == rs2 is legal: both enable vectors carry the same bit, and both operands are equal.
- rsp_valid never drops without rsp_ready, except on reset.

Decomposition:
- Package regbus_pkg: XLEN, NREGS, AW constants; state enum type (IDLE, DRIVE, HOLD); reg_addr_t and word_t typedefs.
- Sub-module onehot_dec (AW to NREGS with enable input, bit 0 forced low), instantiated three times: enable_a, enable_b, store.

Test Plan:
- Reset, then write x5 = 0x1234_5678 and x6 = 0xDEAD_BEEF via wr_en; request rs1 = 5, rs2 = 6 -> enable_a = 1<<5 and enable_b = 1<<6 for exactly one cycle; rsp_valid two cycles after acceptance with 0x12345678 / 0xDEADBEEF.
- Request rs1 = 0, rs2 = 0 with the buses driven to 0xFFFF_FFFF -> enable_a = enable_b = 0 throughout; operands = 0; wr_en to addr 0 -> store = 0.
- Request rs1 = 7 while wr_en writes x7 = 0xA5A5_A5A5 during the DRIVE cycle (bank still holds 0x1) -> rs1_data = 0xA5A5_A5A5.
- Hold rsp_ready low for 5 cycles, writing x5 = 0x42 in HOLD -> rsp_valid stays 1, rs1_data becomes 0x42, req_ready = 0; raise rsp_ready together with req_valid -> next DRIVE follows immediately.
- Assert reset during DRIVE -> next cycle enables = 0, rsp_valid = 0, state IDLE; that request yields no response.
- rs1 = rs2 = 9 (x9 = 0x99) -> enable_a = enable_b = 1<<9; both operands 0x99.
